// File: rtl/windowed_energy_pkg.sv
// Shared types and width helpers for the sliding-window energy stage.
package windowed_energy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ACCUM  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  // Channel tag width; a single channel still carries a 1-bit tag.
  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Ring pointer width; wraps naturally because WINDOW is a power of two.
  function automatic int ptr_w(input int window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

  // Fill counter must be able to hold WINDOW itself.
  function automatic int fill_w(input int window);
    return $clog2(window) + 1;
  endfunction

  // Smallest accumulator that holds WINDOW full-scale squares.
  function automatic int min_energy_w(input int sample_width, input int window);
    return 2 * sample_width + $clog2(window);
  endfunction

endpackage

// File: rtl/window_ring_buffer.sv
// Per-channel sample history: simple dual-port RAM, registered read, no reset.
module window_ring_buffer
  import windowed_energy_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int WINDOW       = 16,
  parameter int CHANNELS     = 1
) (
  input  logic                                        clock,
  input  logic                                        rd_en_i,
  input  logic [ch_w(CHANNELS)+ptr_w(WINDOW)-1:0]     rd_addr_i,
  output logic [SAMPLE_WIDTH-1:0]                     rd_data_o,
  input  logic                                        wr_en_i,
  input  logic [ch_w(CHANNELS)+ptr_w(WINDOW)-1:0]     wr_addr_i,
  input  logic [SAMPLE_WIDTH-1:0]                     wr_data_i
);

  localparam int DEPTH = CHANNELS * WINDOW;

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [SAMPLE_WIDTH-1:0] rd_data_q;

  // Write port and registered read port; callers never address an absent channel.
  always_ff @(posedge clock) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/windowed_energy.sv
// Multi-channel sliding-window energy: running sum of squares updated per sample.
module windowed_energy
  import windowed_energy_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ENERGY_WIDTH = 40,
  parameter int WINDOW       = 16,
  parameter int HOP          = 1,
  parameter int CHANNELS     = 1,
  parameter int SIGNED       = 1
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [SAMPLE_WIDTH-1:0]       sample_data,
  input  logic [ch_w(CHANNELS)-1:0]     sample_channel,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [ENERGY_WIDTH-1:0]       energy_data,
  output logic [ch_w(CHANNELS)-1:0]     energy_channel,
  output logic                          energy_valid,
  input  logic                          energy_ready
);

  localparam int CH_W   = ch_w(CHANNELS);
  localparam int PTR_W  = ptr_w(WINDOW);
  localparam int FILL_W = fill_w(WINDOW);

  if (ENERGY_WIDTH < min_energy_w(SAMPLE_WIDTH, WINDOW)) begin : g_chk_width
    $error("windowed_energy: ENERGY_WIDTH too small for SAMPLE_WIDTH and WINDOW");
  end
  if (WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0) begin : g_chk_window
    $error("windowed_energy: WINDOW must be a power of two >= 2");
  end
  if (HOP < 1 || HOP > WINDOW || CHANNELS < 1) begin : g_chk_hop
    $error("windowed_energy: HOP must be 1..WINDOW and CHANNELS >= 1");
  end

  // Square with sign handling; the true product always fits in 2*SAMPLE_WIDTH bits.
  function automatic logic [ENERGY_WIDTH-1:0] square(input logic [SAMPLE_WIDTH-1:0] x);
    logic signed [2*SAMPLE_WIDTH-1:0] xe;
    logic        [2*SAMPLE_WIDTH-1:0] p;
    if (SIGNED != 0) xe = {{SAMPLE_WIDTH{x[SAMPLE_WIDTH-1]}}, x};
    else             xe = {{SAMPLE_WIDTH{1'b0}}, x};
    p = xe * xe;
    return {{(ENERGY_WIDTH-2*SAMPLE_WIDTH){1'b0}}, p};
  endfunction

  state_e                   state_q;
  logic                     ready_q;
  logic [SAMPLE_WIDTH-1:0]  cap_data_q;
  logic [CH_W-1:0]          cap_ch_q;
  logic [ENERGY_WIDTH-1:0]  result_q;
  logic [CH_W-1:0]          result_ch_q;
  logic [ENERGY_WIDTH-1:0]  energy_data_q;
  logic [CH_W-1:0]          energy_ch_q;
  logic                     energy_valid_q;

  logic [ENERGY_WIDTH-1:0]  total_q  [CHANNELS];
  logic [PTR_W-1:0]         wr_ptr_q [CHANNELS];
  logic [FILL_W-1:0]        fill_q   [CHANNELS];
  logic [FILL_W-1:0]        hop_q    [CHANNELS];

  logic                     ch_ok;
  logic [CH_W-1:0]          ch_idx;
  logic                     full_now;
  logic [FILL_W-1:0]        fill_d;
  logic [FILL_W-1:0]        hop_d;
  logic [PTR_W-1:0]         wr_ptr_d;
  logic [ENERGY_WIDTH-1:0]  sq_new;
  logic [ENERGY_WIDTH-1:0]  sq_old;
  logic [ENERGY_WIDTH-1:0]  total_d;
  logic                     emit_d;
  logic [SAMPLE_WIDTH-1:0]  old_sample;
  logic [CH_W+PTR_W-1:0]    ring_addr;

  // Per-sample update: oldest square is ignored until the window has filled.
  always_comb begin
    ch_ok    = (32'(cap_ch_q) < 32'(CHANNELS));
    ch_idx   = ch_ok ? cap_ch_q : '0;
    full_now = (fill_q[ch_idx] == FILL_W'(WINDOW));
    fill_d   = full_now ? fill_q[ch_idx] : fill_q[ch_idx] + FILL_W'(1);
    wr_ptr_d = wr_ptr_q[ch_idx] + PTR_W'(1);
    sq_new   = square(cap_data_q);
    sq_old   = full_now ? square(old_sample) : '0;
    total_d  = total_q[ch_idx] + sq_new - sq_old;
    if (!full_now) begin
      hop_d  = '0;
      emit_d = (fill_d == FILL_W'(WINDOW));
    end else if (hop_q[ch_idx] == FILL_W'(HOP - 1)) begin
      hop_d  = '0;
      emit_d = 1'b1;
    end else begin
      hop_d  = hop_q[ch_idx] + FILL_W'(1);
      emit_d = 1'b0;
    end
  end

  assign ring_addr = {ch_idx, wr_ptr_q[ch_idx]};

  window_ring_buffer #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .WINDOW       (WINDOW),
    .CHANNELS     (CHANNELS)
  ) u_ring (
    .clock     (clock),
    .rd_en_i   (state_q == FETCH && ch_ok),
    .rd_addr_i (ring_addr),
    .rd_data_o (old_sample),
    .wr_en_i   (state_q == ACCUM && ch_ok),
    .wr_addr_i (ring_addr),
    .wr_data_i (cap_data_q)
  );

  // Capture the accepted sample and the freshly computed total (datapath, no reset).
  always_ff @(posedge clock) begin
    if (state_q == IDLE && sample_valid && ready_q) begin
      cap_data_q <= sample_data;
      cap_ch_q   <= sample_channel;
    end
    if (state_q == ACCUM) begin
      result_q    <= total_d;
      result_ch_q <= cap_ch_q;
    end
  end

  // Control FSM, per-channel running state and the registered result port.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      ready_q        <= 1'b0;
      energy_data_q  <= '0;
      energy_ch_q    <= '0;
      energy_valid_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        total_q[c]  <= '0;
        wr_ptr_q[c] <= '0;
        fill_q[c]   <= '0;
        hop_q[c]    <= '0;
      end
    end else begin
      if (energy_valid_q && energy_ready) energy_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (sample_valid && ready_q) begin
            ready_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (ch_ok) begin
            state_q <= ACCUM;
          end else begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        ACCUM: begin
          total_q[ch_idx]  <= total_d;
          wr_ptr_q[ch_idx] <= wr_ptr_d;
          fill_q[ch_idx]   <= fill_d;
          hop_q[ch_idx]    <= hop_d;
          if (emit_d) begin
            state_q <= OUTPUT;
          end else begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        OUTPUT: begin
          if (!(energy_valid_q && !energy_ready)) begin
            energy_data_q  <= result_q;
            energy_ch_q    <= result_ch_q;
            energy_valid_q <= 1'b1;
            ready_q        <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_ready   = ready_q;
  assign energy_data    = energy_data_q;
  assign energy_channel = energy_ch_q;
  assign energy_valid   = energy_valid_q;

endmodule

// File: tb/tb_windowed_energy.sv
// Directed bench: DUT A (W=4, HOP=1, 3 channels, signed), DUT B (W=4, HOP=2, unsigned).
module tb_windowed_energy;

  logic        clock = 1'b0;
  logic        resetn;
  logic        sel;
  logic [15:0] s_data;
  logic [1:0]  s_ch;
  logic        s_valid;
  logic        e_ready;

  logic        a_sready, a_evalid, b_sready, b_evalid;
  logic [39:0] a_edata, b_edata;
  logic [1:0]  a_ech;
  logic [0:0]  b_ech;

  logic        obs_sready, obs_evalid;
  logic [39:0] obs_edata;
  logic [1:0]  obs_ech;

  int checks   = 0;
  int failures = 0;
  int lat;

  always #5 clock = ~clock;

  windowed_energy #(
    .SAMPLE_WIDTH(16), .ENERGY_WIDTH(40), .WINDOW(4), .HOP(1), .CHANNELS(3), .SIGNED(1)
  ) dut_a (
    .clock(clock), .resetn(resetn),
    .sample_data(s_data), .sample_channel(s_ch), .sample_valid(s_valid & ~sel),
    .sample_ready(a_sready),
    .energy_data(a_edata), .energy_channel(a_ech), .energy_valid(a_evalid),
    .energy_ready(e_ready)
  );

  windowed_energy #(
    .SAMPLE_WIDTH(16), .ENERGY_WIDTH(40), .WINDOW(4), .HOP(2), .CHANNELS(1), .SIGNED(0)
  ) dut_b (
    .clock(clock), .resetn(resetn),
    .sample_data(s_data), .sample_channel(s_ch[0]), .sample_valid(s_valid & sel),
    .sample_ready(b_sready),
    .energy_data(b_edata), .energy_channel(b_ech), .energy_valid(b_evalid),
    .energy_ready(e_ready)
  );

  assign obs_sready = sel ? b_sready : a_sready;
  assign obs_evalid = sel ? b_evalid : a_evalid;
  assign obs_edata  = sel ? b_edata  : a_edata;
  assign obs_ech    = sel ? {1'b0, b_ech} : a_ech;

  task automatic chk(input logic [63:0] got, input logic [63:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Offer one sample from a negedge; return at the negedge after acceptance.
  task automatic send(input logic [15:0] d, input logic [1:0] c);
    int n;
    n = 0;
    s_data = d; s_ch = c; s_valid = 1'b1;
    while (!obs_sready && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk(n < 40, 1, "accept_timeout");
    if (n < 40) @(posedge clock);
    #1 s_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic expect_res(input logic [39:0] d, input logic [1:0] c, input string tag,
                            output int latency);
    int n;
    n = 0;
    while (!obs_evalid && n < 30) begin
      @(negedge clock);
      n++;
    end
    latency = n;
    chk(obs_evalid, 1, {tag, "_valid"});
    chk(obs_edata, d, tag);
    chk(obs_ech, c, {tag, "_ch"});
    @(negedge clock);
  endtask

  task automatic expect_none(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (obs_evalid) seen = 1'b1;
    end
    chk(seen, 0, tag);
  endtask

  logic [39:0] exp_b [1:8];
  logic [15:0] ninth;

  initial begin
    resetn = 1'b0; sel = 1'b0; s_data = '0; s_ch = '0; s_valid = 1'b0; e_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk(a_evalid, 0, "rst_valid");
    chk(a_edata, 0, "rst_data");
    chk(a_ech, 0, "rst_ch");
    chk(a_sready, 0, "rst_ready");
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    chk(a_sready, 1, "ready_after_rst");

    // Channel 0: 1,2,3 silent, then 30 and 54.
    send(16'd1, 2'd0); expect_none("no_out_s1");
    send(16'd2, 2'd0); expect_none("no_out_s2");
    send(16'd3, 2'd0); expect_none("no_out_s3");
    send(16'd4, 2'd0); expect_res(40'd30, 2'd0, "e30", lat);
    chk(lat, 3, "first_latency");
    send(16'd5, 2'd0); expect_res(40'd54, 2'd0, "e54", lat);

    // Channel 1 signed: -3 x4, then full-scale positive and negative samples.
    for (int i = 0; i < 3; i++) begin
      send(16'hFFFD, 2'd1); expect_none("no_out_neg");
    end
    send(16'hFFFD, 2'd1); expect_res(40'd36, 2'd1, "e36", lat);
    send(16'h7FFF, 2'd1); expect_res(40'd1073676316, 2'd1, "e_maxpos", lat);
    send(16'h8000, 2'd1); expect_res(40'd2147418131, 2'd1, "e_maxneg", lat);

    // Interleave ch0 ones (window already full) with ch2 twos (fresh).
    send(16'd1, 2'd0); expect_res(40'd51, 2'd0, "il_ch0_a", lat);
    send(16'd2, 2'd2); expect_none("il_ch2_a");
    send(16'd1, 2'd0); expect_res(40'd43, 2'd0, "il_ch0_b", lat);
    send(16'd2, 2'd2); expect_none("il_ch2_b");
    send(16'd1, 2'd0); expect_res(40'd28, 2'd0, "il_ch0_c", lat);
    send(16'd2, 2'd2); expect_none("il_ch2_c");
    send(16'd1, 2'd0); expect_res(40'd4, 2'd0, "il_ch0_d", lat);
    send(16'd2, 2'd2); expect_res(40'd16, 2'd2, "il_ch2_d", lat);

    // Out-of-range channel is dropped and disturbs nothing.
    send(16'd100, 2'd3); expect_none("drop_ch3");
    send(16'd0, 2'd0); expect_res(40'd3, 2'd0, "after_drop_ch0", lat);
    send(16'd0, 2'd2); expect_res(40'd12, 2'd2, "after_drop_ch2", lat);

    // Back-pressure across two emits.
    e_ready = 1'b0;
    send(16'd5, 2'd0);
    repeat (5) @(negedge clock);
    chk(a_evalid, 1, "stall_valid1");
    chk(a_edata, 27, "stall_data1");
    send(16'd6, 2'd0);
    repeat (6) @(negedge clock);
    chk(a_edata, 27, "stall_hold_data");
    chk(a_evalid, 1, "stall_hold_valid");
    chk(a_sready, 0, "stall_ready_low");
    e_ready = 1'b1;
    @(negedge clock);
    chk(a_evalid, 1, "stall_valid2");
    chk(a_edata, 62, "stall_data2");
    @(negedge clock);
    chk(a_evalid, 0, "stall_drained");
    chk(a_sready, 1, "stall_ready_back");

    // Reset during FETCH of the 4th sample, then a clean window of ones.
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    ninth = 16'd9;
    for (int i = 0; i < 3; i++) begin
      send(ninth, 2'd0); expect_none("pre_rst_fill");
    end
    s_data = ninth; s_ch = 2'd0; s_valid = 1'b1;
    begin
      int n;
      n = 0;
      while (!a_sready && n < 40) begin @(negedge clock); n++; end
      chk(n < 40, 1, "rst_accept_timeout");
    end
    @(posedge clock);
    #1 s_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clock);
    chk(a_evalid, 0, "midrst_valid");
    chk(a_sready, 0, "midrst_ready");
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      send(16'd1, 2'd0); expect_none("post_rst_fill");
    end
    send(16'd1, 2'd0); expect_res(40'd4, 2'd0, "post_rst_e4", lat);

    // DUT B: HOP=2 emits after samples 4, 6 and 8 only.
    sel = 1'b1;
    @(negedge clock);
    exp_b[4] = 40'd30; exp_b[6] = 40'd86; exp_b[8] = 40'd174;
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), 2'd0);
      if (i == 4 || i == 6 || i == 8) expect_res(exp_b[i], 2'd0, "hop2_res", lat);
      else expect_none("hop2_none");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/windowed_energy.md
# windowed_energy

Parametrised, multi-channel successor to the block-recompute energy stage in the audio detection path. It computes the sliding-window energy, the sum of squares over the last WINDOW samples, per channel. Each accepted sample updates a running total incrementally: add new², subtract oldest². A result is emitted every HOP samples once the window is full. It sits between the sample source and the threshold/clap detector, with ready/valid handshakes on both sides.

## Interface
- SAMPLE_WIDTH, 16, sample width in bits
- ENERGY_WIDTH, 40, result width; elaboration error if < 2*SAMPLE_WIDTH+clog2(WINDOW)
- WINDOW, 16, samples per window; power of two, ≥2
- HOP, 1, samples between emitted results per channel; 1..WINDOW
- CHANNELS, 1, number of time-multiplexed channels; ≥1
- SIGNED, 1, 1 = two's-complement samples, 0 = unsigned
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- sample_data  in  SAMPLE_WIDTH  input sample
- sample_channel  in  CH_W=max(1,clog2(CHANNELS))  channel tag of sample
- sample_valid  in  1  sample offered
- sample_ready  out  1  block can accept
- energy_data  out  ENERGY_WIDTH  window energy
- energy_channel  out  CH_W  channel of result
- energy_valid  out  1  result held
- energy_ready  in  1  consumer accepts

## Operation
- All outputs reset to 0, except sample_ready, which is 1 in the first IDLE cycle after reset release.
- FSM states and transitions:
  - IDLE: sample_ready=1. On sample_valid&&sample_ready, capture data and channel, go to FETCH.
  - FETCH: registered read of the oldest sample at (channel, wr_ptr[channel]). Go to ACCUM.
  - ACCUM: compute total[ch] + new² − old²; old² is forced to 0 while fill[ch] < WINDOW. Write the new sample to the ring at wr_ptr. Increment wr_ptr (wraps mod WINDOW), fill (saturates at WINDOW) and hop[ch].
    - emit: fill reaches WINDOW this sample, and hop hits HOP−1 (hop then resets to 0). Go to OUTPUT.
    - no emit: go to IDLE.
  - OUTPUT: stall while energy_valid&&!energy_ready. Otherwise load energy_data/energy_channel, set energy_valid, go to IDLE.
- hop[ch] counts only samples accepted after the window is full. The first emit happens on the WINDOW-th sample; later emits follow every HOP samples.
- Squares use signed multiplication when SIGNED=1: −32768² = 2³⁰. All arithmetic is zero-extended to ENERGY_WIDTH. The width rule guarantees the total never overflows, and subtraction never underflows.
- sample_channel ≥ CHANNELS: the sample is accepted and dropped, with no state change and no output; the FSM returns to IDLE via FETCH.
- energy_valid clears on energy_valid&&energy_ready unless OUTPUT reloads it in the same cycle. Simultaneous consume and load means new data is valid next cycle.
- Reset mid-operation clears FSM, totals, pointers, fill and hop counters, and all outputs. Ring memory is not cleared; fill gating makes its stale contents irrelevant.

## Timing
- Accept edge = cycle 0.
- FETCH = cycle 1, ACCUM = cycle 2.
- With emit: OUTPUT = cycle 3; energy_valid is high after edge 3 if unstalled.
- sample_ready is low from the edge after acceptance until return to IDLE.
- Throughput per sample: 3 cycles without emit; 4+stall cycles with emit.
- energy_data and energy_channel are stable while energy_valid&&!energy_ready.

## Structure
- Package windowed_energy_pkg holds:
  - state enum {IDLE, FETCH, ACCUM, OUTPUT}
  - clog2-derived widths CH_W, PTR_W, FILL_W
  - the ENERGY_WIDTH minimum-width function used by the elaboration check
- One sub-module, window_ring_buffer:
  - CHANNELS×WINDOW × SAMPLE_WIDTH simple dual-port RAM with registered read
  - address {channel, ptr}
  - no reset

## Test plan
- W=4, HOP=1, CH=1, samples 1,2,3,4,5 → no output for the first three samples; then 30, then 54. energy_valid is first high 3 edges after the 4th accept.
- SIGNED=1, W=4, samples −3,−3,−3,−3 → 36. Then 32767 → 27+1073676289 = 1073676316.
- HOP=2, W=4, samples 1..8 → results 30, 86, 174, after the 4th, 6th and 8th samples only.
- CH=2, interleaved ch0:1,1,1,1 and ch1:2,2,2,2 → ch0 result 4 then ch1 result 16, each tagged correctly. Channel 3 with CHANNELS=3 → dropped, no output.
- Hold energy_ready=0 across two emits → first result stays stable, FSM stalls in OUTPUT, sample_ready low. Raise energy_ready → results delivered in order with none lost.
- Assert resetn low during FETCH after 3 samples, then send 4 samples of value 1 → first result is 4, with no contribution from pre-reset data.
